// File: rtl/mbuf_pkg.sv
// Shared helpers for the multi-page buffer ring: width math, ring index
// advance and the bit positions of the sticky error register.
package mbuf_pkg;

  localparam int ERR_OVERFLOW  = 0;
  localparam int ERR_UNDERFLOW = 1;
  localparam int ERR_BITS      = 2;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int unsigned v);
    int          r;
    int unsigned x;
    r = 0;
    x = (v > 0) ? v - 1 : 0;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  // Ring advance with explicit wrap so page counts need not be powers of 2.
  function automatic int unsigned next_idx(input int unsigned i, input int unsigned n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/mbuf_sdpram.sv
// Simple dual-port RAM: one write port, one registered read port, one clock.
// Read-during-write to the same word returns the old contents.
module mbuf_sdpram #(
  parameter int P_DEPTH = 1024,
  parameter int P_AW    = 10,
  parameter int P_DW    = 128
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            we_i,
  input  logic [P_AW-1:0] waddr_i,
  input  logic [P_DW-1:0] wdata_i,
  input  logic [P_AW-1:0] raddr_i,
  output logic [P_DW-1:0] rdata_o
);

  logic [P_DW-1:0] mem_q [P_DEPTH];
  logic [P_DW-1:0] rdata_q;

  // Storage array: written only, never reset.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Output register: cleared by reset and by the synchronous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    rdata_q <= '0;
    else if (clr_i) rdata_q <= '0;
    else            rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/multi_buffer_ring.sv
// Ring of equal pages: the writer fills and commits page wr_idx, the reader
// drains and releases page rd_idx. Commit/release are single-cycle pulses;
// per-page full flag and length tag live here, data lives in the RAM.
module multi_buffer_ring
  import mbuf_pkg::*;
#(
  parameter int P_NUM_BUFS   = 4,
  parameter int P_ADDR_WIDTH = 8,
  parameter int P_DATA_WIDTH = 128,
  parameter int P_LEN_WIDTH  = 16,
  localparam int CW          = clog2(P_NUM_BUFS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [P_ADDR_WIDTH-1:0] wr_addr,
  input  logic [P_DATA_WIDTH-1:0] wr_din,
  input  logic                    run,
  input  logic [P_LEN_WIDTH-1:0]  len_in,
  output logic                    wr_busy,
  input  logic [P_ADDR_WIDTH-1:0] rd_addr,
  output logic [P_DATA_WIDTH-1:0] rd_dout,
  output logic                    rd_valid,
  output logic [P_LEN_WIDTH-1:0]  len_out,
  input  logic                    done,
  output logic [CW-1:0]           count,
  output logic                    err_overflow,
  output logic                    err_underflow
);

  localparam int IW    = clog2(P_NUM_BUFS);
  localparam int RAW   = IW + P_ADDR_WIDTH;
  localparam int DEPTH = P_NUM_BUFS * (2 ** P_ADDR_WIDTH);

  logic [P_NUM_BUFS-1:0]  full_q, full_d;
  logic [P_LEN_WIDTH-1:0] len_q [P_NUM_BUFS];
  logic [P_LEN_WIDTH-1:0] len_d [P_NUM_BUFS];
  logic [IW-1:0]          wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic [CW-1:0]          count_q, count_d;
  logic [ERR_BITS-1:0]    err_q, err_d;
  logic                   run_acc, done_acc, ram_we;

  // Status decode of the current write/read pages and accepted handshakes.
  always_comb begin
    wr_busy  = full_q[wr_idx_q];
    rd_valid = full_q[rd_idx_q];
    len_out  = rd_valid ? len_q[rd_idx_q] : '0;
    run_acc  = run & ~wr_busy;
    done_acc = done & rd_valid;
    ram_we   = wr_en & ~wr_busy;
  end

  // Next-state: flush wins; otherwise commit and release act on distinct pages.
  always_comb begin
    full_d   = full_q;
    len_d    = len_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    count_d  = count_q;
    err_d    = err_q;
    if (flush) begin
      full_d   = '0;
      for (int i = 0; i < P_NUM_BUFS; i++) len_d[i] = '0;
      wr_idx_d = '0;
      rd_idx_d = '0;
      count_d  = '0;
      err_d    = '0;
    end else begin
      if (run_acc) begin
        full_d[wr_idx_q] = 1'b1;
        len_d[wr_idx_q]  = len_in;
        wr_idx_d         = IW'(next_idx(32'(wr_idx_q), P_NUM_BUFS));
      end
      if (done_acc) begin
        full_d[rd_idx_q] = 1'b0;
        len_d[rd_idx_q]  = '0;
        rd_idx_d         = IW'(next_idx(32'(rd_idx_q), P_NUM_BUFS));
      end
      case ({run_acc, done_acc})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if ((run | wr_en) & wr_busy) err_d[ERR_OVERFLOW]  = 1'b1;
      if (done & ~rd_valid)        err_d[ERR_UNDERFLOW] = 1'b1;
    end
  end

  // Page state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q   <= '0;
      for (int i = 0; i < P_NUM_BUFS; i++) len_q[i] <= '0;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      count_q  <= '0;
      err_q    <= '0;
    end else begin
      full_q   <= full_d;
      len_q    <= len_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  assign count         = count_q;
  assign err_overflow  = err_q[ERR_OVERFLOW];
  assign err_underflow = err_q[ERR_UNDERFLOW];

  // Page index sits above the word address.
  mbuf_sdpram #(
    .P_DEPTH (DEPTH),
    .P_AW    (RAW),
    .P_DW    (P_DATA_WIDTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clr_i   (flush),
    .we_i    (ram_we),
    .waddr_i ({wr_idx_q, wr_addr}),
    .wdata_i (wr_din),
    .raddr_i ({rd_idx_q, rd_addr}),
    .rdata_o (rd_dout)
  );

endmodule

// File: tb/tb_multi_buffer_ring.sv
// Bench for multi_buffer_ring: one 4-page instance (default widths) and one
// 3-page instance (narrow). Stimulus pushes expected values at posedge+1;
// a monitor pops and compares on the following negedge.
module tb_multi_buffer_ring;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A: 4 pages, default widths ----------------
  logic         a_flush = 0, a_wr_en = 0, a_run = 0, a_done = 0;
  logic [7:0]   a_wr_addr = 0, a_rd_addr = 0;
  logic [127:0] a_wr_din = 0, a_rd_dout;
  logic [15:0]  a_len_in = 0, a_len_out;
  logic         a_wr_busy, a_rd_valid, a_err_ovf, a_err_unf;
  logic [2:0]   a_count;

  multi_buffer_ring u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_din(a_wr_din), .run(a_run), .len_in(a_len_in), .wr_busy(a_wr_busy),
    .rd_addr(a_rd_addr), .rd_dout(a_rd_dout), .rd_valid(a_rd_valid), .len_out(a_len_out),
    .done(a_done), .count(a_count), .err_overflow(a_err_ovf), .err_underflow(a_err_unf)
  );

  // ---------------- DUT B: 3 pages, 16 words x 16 bits ----------------
  logic        b_flush = 0, b_wr_en = 0, b_run = 0, b_done = 0;
  logic [3:0]  b_wr_addr = 0, b_rd_addr = 0;
  logic [15:0] b_wr_din = 0, b_rd_dout;
  logic [15:0] b_len_in = 0, b_len_out;
  logic        b_wr_busy, b_rd_valid, b_err_ovf, b_err_unf;
  logic [1:0]  b_count;

  multi_buffer_ring #(
    .P_NUM_BUFS(3), .P_ADDR_WIDTH(4), .P_DATA_WIDTH(16), .P_LEN_WIDTH(16)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_din(b_wr_din), .run(b_run), .len_in(b_len_in), .wr_busy(b_wr_busy),
    .rd_addr(b_rd_addr), .rd_dout(b_rd_dout), .rd_valid(b_rd_valid), .len_out(b_len_out),
    .done(b_done), .count(b_count), .err_overflow(b_err_ovf), .err_underflow(b_err_unf)
  );

  // ---------------- scoreboard ----------------
  localparam int DA = 0, DB = 1;
  localparam int F_BUSY = 0, F_VALID = 1, F_LEN = 2, F_CNT = 3, F_OVF = 4, F_UNF = 5, F_DOUT = 6;

  logic [127:0] exp_q[$];
  int           sel_q[$];
  int           checks = 0;
  int           failures = 0;

  function automatic string sel_name(input int s);
    string f;
    case (s % 8)
      F_BUSY:  f = "wr_busy";
      F_VALID: f = "rd_valid";
      F_LEN:   f = "len_out";
      F_CNT:   f = "count";
      F_OVF:   f = "err_overflow";
      F_UNF:   f = "err_underflow";
      default: f = "rd_dout";
    endcase
    return {(s / 8 == DA) ? "a." : "b.", f};
  endfunction

  function automatic logic [127:0] actual(input int s);
    case (s)
      DA*8+F_BUSY:  return 128'(a_wr_busy);
      DA*8+F_VALID: return 128'(a_rd_valid);
      DA*8+F_LEN:   return 128'(a_len_out);
      DA*8+F_CNT:   return 128'(a_count);
      DA*8+F_OVF:   return 128'(a_err_ovf);
      DA*8+F_UNF:   return 128'(a_err_unf);
      DA*8+F_DOUT:  return a_rd_dout;
      DB*8+F_BUSY:  return 128'(b_wr_busy);
      DB*8+F_VALID: return 128'(b_rd_valid);
      DB*8+F_LEN:   return 128'(b_len_out);
      DB*8+F_CNT:   return 128'(b_count);
      DB*8+F_OVF:   return 128'(b_err_ovf);
      DB*8+F_UNF:   return 128'(b_err_unf);
      default:      return 128'(b_rd_dout);
    endcase
  endfunction

  // Monitor: compare everything queued since the last negedge.
  always @(negedge clk) begin
    int           s;
    logic [127:0] e, a;
    while (sel_q.size() > 0) begin
      s = sel_q.pop_front();
      e = exp_q.pop_front();
      a = actual(s);
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL %s actual=%0h expected=%0h @%0t", sel_name(s), a, e, $time);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [127:0] e);
    sel_q.push_back(s);
    exp_q.push_back(e);
  endtask

  task automatic exp_state(input int d, input logic busy, input logic valid,
                           input int len, input int cnt, input logic ovf, input logic unf);
    push(d*8+F_BUSY,  128'(busy));
    push(d*8+F_VALID, 128'(valid));
    push(d*8+F_LEN,   128'(len));
    push(d*8+F_CNT,   128'(cnt));
    push(d*8+F_OVF,   128'(ovf));
    push(d*8+F_UNF,   128'(unf));
  endtask

  task automatic b_read(input logic [3:0] addr, input logic [15:0] e);
    b_rd_addr = addr;
    step();
    push(DB*8+F_DOUT, 128'(e));
  endtask

  // Expected FIFO of committed B pages (length tag and word-0 data).
  int          len_m[$];
  logic [15:0] dat_m[$];

  initial begin
    // Reset state, checked while rst_n is still low.
    step();
    exp_state(DA, 0, 0, 0, 0, 0, 0);
    exp_state(DB, 0, 0, 0, 0, 0, 0);
    push(DA*8+F_DOUT, 128'd0);
    push(DB*8+F_DOUT, 128'd0);
    step();
    rst_n = 1'b1;
    step();
    step();
    exp_state(DA, 0, 0, 0, 0, 0, 0);
    exp_state(DB, 0, 0, 0, 0, 0, 0);

    // A: fill page 0 words 0..3, commit len 4, read word 2, release.
    for (int i = 0; i < 4; i++) begin
      a_wr_en = 1; a_wr_addr = 8'(i); a_wr_din = 128'(32'hA0 + i);
      step();
    end
    a_wr_en = 0; a_run = 1; a_len_in = 16'd4;
    step();
    a_run = 0;
    exp_state(DA, 0, 1, 4, 1, 0, 0);
    a_rd_addr = 8'd2;
    step();
    push(DA*8+F_DOUT, 128'hA2);
    a_done = 1;
    step();
    a_done = 0;
    exp_state(DA, 0, 0, 0, 0, 0, 0);

    // B: three commits (word0 = 0x100+k, word1 = 0x150+k, len 10+k).
    for (int k = 0; k < 3; k++) begin
      b_wr_en = 1; b_wr_addr = 4'd0; b_wr_din = 16'(16'h100 + k);
      step();
      b_wr_addr = 4'd1; b_wr_din = 16'(16'h150 + k); b_run = 1; b_len_in = 16'(10 + k);
      step();
      b_wr_en = 0; b_run = 0;
      len_m.push_back(10 + k);
      dat_m.push_back(16'(16'h100 + k));
      push(DB*8+F_CNT, 128'(k + 1));
    end
    exp_state(DB, 1, 1, 10, 3, 0, 0);

    // Fourth commit while full is rejected and flagged.
    b_run = 1; b_len_in = 16'd99;
    step();
    b_run = 0;
    exp_state(DB, 1, 1, 10, 3, 1, 0);

    // Release one page, then simultaneous release+commit ten times.
    b_done = 1;
    step();
    b_done = 0;
    void'(len_m.pop_front());
    void'(dat_m.pop_front());
    exp_state(DB, 0, 1, len_m[0], 2, 1, 0);
    for (int k = 0; k < 10; k++) begin
      b_done = 1; b_run = 1; b_len_in = 16'(20 + k);
      b_wr_en = 1; b_wr_addr = 4'd0; b_wr_din = 16'(16'h200 + k);
      step();
      void'(len_m.pop_front());
      void'(dat_m.pop_front());
      len_m.push_back(20 + k);
      dat_m.push_back(16'(16'h200 + k));
      exp_state(DB, 0, 1, len_m[0], 2, 1, 0);
    end
    b_done = 0; b_run = 0; b_wr_en = 0;
    b_read(4'd0, dat_m[0]);

    // Drain, then underflow.
    for (int k = 0; k < 2; k++) begin
      b_done = 1;
      step();
      b_done = 0;
      void'(len_m.pop_front());
      push(DB*8+F_CNT, 128'(1 - k));
    end
    b_done = 1;
    step();
    b_done = 0;
    exp_state(DB, 0, 0, 0, 0, 1, 1);

    // Read index unchanged by the rejected release: next commit is visible.
    b_run = 1; b_len_in = 16'd55;
    step();
    b_run = 0;
    exp_state(DB, 0, 1, 55, 1, 1, 1);

    // Flush clears state and errors; indices restart at page 0.
    b_flush = 1;
    step();
    b_flush = 0;
    exp_state(DB, 0, 0, 0, 0, 0, 0);
    b_run = 1; b_len_in = 16'd66;
    step();
    b_run = 0;
    exp_state(DB, 0, 1, 66, 1, 0, 0);
    b_read(4'd1, 16'h150);

    // Asynchronous reset in the middle of a fill.
    b_run = 1; b_len_in = 16'd67;
    step();
    b_run = 0;
    push(DB*8+F_CNT, 128'd2);
    b_wr_en = 1; b_wr_addr = 4'd3; b_wr_din = 16'hEEE;
    step();
    rst_n = 1'b0;
    #1;
    exp_state(DB, 0, 0, 0, 0, 0, 0);
    push(DB*8+F_DOUT, 128'd0);
    step();
    b_wr_en = 0;
    rst_n = 1'b1;
    step();
    b_wr_en = 1; b_wr_addr = 4'd0; b_wr_din = 16'h3CD;
    step();
    b_wr_en = 0; b_run = 1; b_len_in = 16'd7;
    step();
    b_run = 0;
    exp_state(DB, 0, 1, 7, 1, 0, 0);
    b_read(4'd0, 16'h3CD);

    // Let the monitor drain, then report.
    step();
    step();
    if (sel_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending", sel_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
